// File: rtl/rhd_cmd_responder.sv
// Chip-side responder for the RHD2000-style 16-bit SPI command link with a 64x8 register map.
// Optional RHD_ADC_TWOS_COMP_EN: CONVERT results are offset-flipped when reg4[6] is set.
module rhd_cmd_responder #(
    parameter logic [7:0]  CHIP_ID     = 8'd1,
    parameter logic [7:0]  NUM_AMPS    = 8'd32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        SCLK,
    input  logic        MOSI,
    input  logic        CS,
    output logic        MISO,
    input  logic [15:0] adc_data,
    output logic        conv_stb,
    output logic [5:0]  conv_chan,
    output logic        frame_err
);

    localparam int unsigned WORD_W    = 16;
    localparam int unsigned CNT_W     = 5;
    localparam int unsigned RAM_DEPTH = 18;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WORD_W + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
    logic                   sclk_q, cs_q;
    logic                   sclk_s, mosi_s, cs_s;
    logic                   sclk_rise_c, sclk_fall_c, cs_fall_c, cs_rise_c;

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [WORD_W-1:0]   shreg;
    logic [WORD_W-1:0]   tx_shift;
    logic [WORD_W-1:0]   slot0, slot1;
    logic [7:0]          ram [RAM_DEPTH];

    logic [5:0]          reg_addr_c;
    logic [7:0]          rd_val_c;
    logic [WORD_W-1:0]   result_c;
    logic                wr_en_c;

    // Input synchronizers plus one extra flop on SCLK and CS for edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
            cs_q      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s      = sclk_sync[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync[SYNC_STAGES-1];
    assign cs_s        = cs_sync[SYNC_STAGES-1];
    assign sclk_rise_c = sclk_s & ~sclk_q;
    assign sclk_fall_c = ~sclk_s & sclk_q;
    assign cs_fall_c   = ~cs_s & cs_q;
    assign cs_rise_c   = cs_s & ~cs_q;

    assign reg_addr_c = shreg[13:8];

    // Register map read: RAM, "INTAN" ROM and identification registers
    always_comb begin
        rd_val_c = 8'h00;
        if (reg_addr_c < 6'(RAM_DEPTH)) begin
            rd_val_c = ram[reg_addr_c[4:0]];
        end else begin
            case (reg_addr_c)
                6'd40:   rd_val_c = 8'h49;
                6'd41:   rd_val_c = 8'h4E;
                6'd42:   rd_val_c = 8'h54;
                6'd43:   rd_val_c = 8'h41;
                6'd44:   rd_val_c = 8'h4E;
                6'd60:   rd_val_c = 8'h01;
                6'd62:   rd_val_c = NUM_AMPS;
                6'd63:   rd_val_c = CHIP_ID;
                default: rd_val_c = 8'h00;
            endcase
        end
    end

    // Command result for the word being decoded
    always_comb begin
        result_c = '0;
        wr_en_c  = 1'b0;
        case (shreg[15:14])
            2'b00: begin
`ifdef RHD_ADC_TWOS_COMP_EN
                result_c = ram[4][6] ? (adc_data ^ 16'h8000) : adc_data;
`else
                result_c = adc_data;
`endif
            end
            2'b01: result_c = '0;
            2'b10: begin
                result_c = {8'hFF, shreg[7:0]};
                wr_en_c  = (reg_addr_c < 6'(RAM_DEPTH));
            end
            default: result_c = {8'h00, rd_val_c};
        endcase
    end

    // Frame FSM, response pipeline and MISO shifter; slot0 is what the next frame transmits
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            tx_shift  <= '0;
            slot0     <= '0;
            slot1     <= '0;
            MISO      <= 1'b0;
            conv_stb  <= 1'b0;
            conv_chan <= '0;
            frame_err <= 1'b0;
            for (int i = 0; i < int'(RAM_DEPTH); i++) begin
                ram[i] <= '0;
            end
        end else begin
            conv_stb  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall_c) begin
                        state    <= SHIFT;
                        bit_cnt  <= '0;
                        MISO     <= slot0[15];
                        tx_shift <= {slot0[14:0], 1'b0};
                    end
                end
                SHIFT: begin
                    if (cs_rise_c) begin
                        MISO <= 1'b0;
                        if (bit_cnt == CNT_FULL) begin
                            state <= DECODE;
                            if (shreg[15:14] == 2'b00) begin
                                conv_stb  <= 1'b1;
                                conv_chan <= shreg[13:8];
                            end
                        end else begin
                            state     <= IDLE;
                            frame_err <= 1'b1;
                        end
                    end else if (sclk_rise_c) begin
                        shreg <= {shreg[14:0], mosi_s};
                        if (bit_cnt != CNT_SAT) begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (sclk_fall_c) begin
                        MISO     <= tx_shift[15];
                        tx_shift <= {tx_shift[14:0], 1'b0};
                    end
                end
                DECODE: begin
                    slot0 <= slot1;
                    slot1 <= result_c;
                    if (wr_en_c) begin
                        ram[reg_addr_c[4:0]] <= shreg[7:0];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rhd_cmd_responder.sv
// Self-checking bench for rhd_cmd_responder: table of command frames, a response scoreboard
// and hand-written sequences for bad frames and mid-frame reset.
module tb_rhd_cmd_responder;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        rstn;
    logic        SCLK, MOSI, CS;
    logic        MISO;
    logic [15:0] adc_data;
    logic        conv_stb;
    logic [5:0]  conv_chan;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int conv_cnt = 0;
    int err_cnt  = 0;
    logic [15:0] exp_q[$];

    typedef struct {
        logic [15:0] word;
        logic [15:0] adc;
        logic [15:0] res;
    } vec_t;

    localparam int NVEC = 24;
    vec_t tbl [NVEC];

`ifdef RHD_ADC_TWOS_COMP_EN
    localparam logic [15:0] CONV_FLIP_EXP = 16'h9234;
`else
    localparam logic [15:0] CONV_FLIP_EXP = 16'h1234;
`endif

    rhd_cmd_responder dut (
        .clk       (clk),
        .rstn      (rstn),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .CS        (CS),
        .MISO      (MISO),
        .adc_data  (adc_data),
        .conv_stb  (conv_stb),
        .conv_chan (conv_chan),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (conv_stb)  conv_cnt <= conv_cnt + 1;
        if (frame_err) err_cnt  <= err_cnt + 1;
    end

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0;
        CS   = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
    endtask

    // One CS-low period with nbits SCLK pulses; MISO captured just before each rising edge
    task automatic spi_frame(input logic [15:0] w, input int nbits, output logic [15:0] rx);
        rx = '0;
        @(negedge clk);
        CS = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? w[15-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            if (i < 16) rx[15-i] = MISO;
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        CS = 1'b1;
        MOSI = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic do_frame(input string name, input logic [15:0] w, input logic [15:0] adc,
                            input logic [15:0] res);
        int c0, e0;
        logic [15:0] rx, want;
        adc_data = adc;
        c0 = conv_cnt;
        e0 = err_cnt;
        spi_frame(w, 16, rx);
        if (exp_q.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            want = exp_q.pop_front();
            check({name, "_miso"}, int'(rx), int'(want));
        end
        exp_q.push_back(res);
        check({name, "_frame_err"}, err_cnt - e0, 0);
        if (w[15:14] == 2'b00) begin
            check({name, "_conv_stb"}, conv_cnt - c0, 1);
            check({name, "_conv_chan"}, int'(conv_chan), int'(w[13:8]));
        end else begin
            check({name, "_no_conv"}, conv_cnt - c0, 0);
        end
    endtask

    task automatic bad_frame(input string name, input logic [15:0] w, input int nbits);
        int c0, e0;
        logic [15:0] rx;
        c0 = conv_cnt;
        e0 = err_cnt;
        spi_frame(w, nbits, rx);
        check({name, "_frame_err"}, err_cnt - e0, 1);
        check({name, "_no_conv"}, conv_cnt - c0, 0);
    endtask

    initial begin
        tbl[0]  = '{16'hE800, 16'h0000, 16'h0049};
        tbl[1]  = '{16'hE900, 16'h0000, 16'h004E};
        tbl[2]  = '{16'hEA00, 16'h0000, 16'h0054};
        tbl[3]  = '{16'hEB00, 16'h0000, 16'h0041};
        tbl[4]  = '{16'hEC00, 16'h0000, 16'h004E};
        tbl[5]  = '{16'h8A5C, 16'h0000, 16'hFF5C};
        tbl[6]  = '{16'hCA00, 16'h0000, 16'h005C};
        tbl[7]  = '{16'h0F00, 16'h1234, 16'h1234};
        tbl[8]  = '{16'hB2AA, 16'h0000, 16'hFFAA};
        tbl[9]  = '{16'hF200, 16'h0000, 16'h0000};
        tbl[10] = '{16'h5500, 16'h0000, 16'h0000};
        tbl[11] = '{16'h6A00, 16'h0000, 16'h0000};
        tbl[12] = '{16'h4123, 16'h0000, 16'h0000};
        tbl[13] = '{16'hFC00, 16'h0000, 16'h0001};
        tbl[14] = '{16'hFE00, 16'h0000, 16'h0020};
        tbl[15] = '{16'hFF00, 16'h0000, 16'h0001};
        tbl[16] = '{16'h0100, 16'hABCD, 16'hABCD};
        tbl[17] = '{16'h2500, 16'h0F0F, 16'h0F0F};
        tbl[18] = '{16'hF100, 16'h0000, 16'h0000};
        tbl[19] = '{16'h91A5, 16'h0000, 16'hFFA5};
        tbl[20] = '{16'hD100, 16'h0000, 16'h00A5};
        tbl[21] = '{16'h9233, 16'h0000, 16'hFF33};
        tbl[22] = '{16'hD200, 16'h0000, 16'h0000};
        tbl[23] = '{16'h8440, 16'h0000, 16'hFF40};

        rstn = 1'b0;
        CS = 1'b1;
        SCLK = 1'b0;
        MOSI = 1'b0;
        adc_data = '0;
        do_reset();

        check("rst_miso", int'(MISO), 0);
        check("rst_conv_stb", int'(conv_stb), 0);
        check("rst_conv_chan", int'(conv_chan), 0);
        check("rst_frame_err", int'(frame_err), 0);

        for (int i = 0; i < NVEC; i++) begin
            do_frame($sformatf("vec%0d", i), tbl[i].word, tbl[i].adc, tbl[i].res);
        end
        do_frame("conv_flip", 16'h0F00, 16'h1234, CONV_FLIP_EXP);
        do_frame("read_reg4", 16'hC400, 16'h0000, 16'h0040);
        do_frame("flush0", 16'h4000, 16'h0000, 16'h0000);
        do_frame("flush1", 16'h4000, 16'h0000, 16'h0000);

        // Discarded frames must not advance the pipeline or fire CONVERT
        do_frame("pre_bad", 16'hFF00, 16'h0000, 16'h0001);
        bad_frame("short12", 16'h0F00, 12);
        bad_frame("empty0", 16'h0F00, 0);
        bad_frame("long17", 16'h0F00, 17);
        do_frame("post_bad0", 16'h4000, 16'h0000, 16'h0000);
        do_frame("post_bad1", 16'h4000, 16'h0000, 16'h0000);
        do_frame("post_bad2", 16'h4000, 16'h0000, 16'h0000);

        // Mid-frame reset while a nonzero response is being shifted out
        do_frame("pre_rst0", 16'hB2AA, 16'h0000, 16'hFFAA);
        do_frame("pre_rst1", 16'hB2AA, 16'h0000, 16'hFFAA);
        do_frame("pre_rst2", 16'hB2AA, 16'h0000, 16'hFFAA);
        @(negedge clk);
        CS = 1'b0;
        for (int i = 0; i < 7; i++) begin
            repeat (HALF) @(negedge clk);
            SCLK = 1'b1;
            repeat (HALF) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        check("mid_frame_bit8", int'(MISO), 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_miso", int'(MISO), 0);
        do_reset();
        do_frame("after_rst0", 16'hCA00, 16'h0000, 16'h0000);
        do_frame("after_rst1", 16'hE800, 16'h0000, 16'h0049);
        do_frame("after_rst2", 16'h4000, 16'h0000, 16'h0000);
        do_frame("after_rst3", 16'h4000, 16'h0000, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
